ni_packetizer: RTL and testbench

Network-interface transmit stage that sits directly upstream of the router's Local input port. It takes a packet command (destination and payload count) plus a payload word stream from the attached core. It emits a valid/ready flit stream of one header flit followed by body flits and a final tail flit. That stream drives Ldata_in/Lvalid_in, and the block observes Lready_out.

---
 rtl/ni_packetizer_if.sv | 27 ++
 rtl/ni_packetizer.sv | 187 ++++++++++++++++++
 tb/tb_ni_packetizer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ni_packetizer_if.sv
// Handshake bundle between ni_packetizer, the attached core (cmd/payload) and the router Local port (flits).
// slave = packetizer side, master = core/router side.
interface ni_packetizer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int AXIS       = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [AXIS-1:0]       cmd_dst;
    logic [11:0]           cmd_len;
    logic                  pl_valid;
    logic                  pl_ready;
    logic [DATA_WIDTH-4:0] pl_data;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_in;

    modport master (
        output cmd_valid, cmd_dst, cmd_len, pl_valid, pl_data, ready_in,
        input  cmd_ready, pl_ready, data_out, valid_out
    );

    modport slave (
        input  cmd_valid, cmd_dst, cmd_len, pl_valid, pl_data, ready_in,
        output cmd_ready, pl_ready, data_out, valid_out
    );
endinterface

// File: rtl/ni_packetizer.sv
// NI transmit stage: turns (dst, len) commands plus a payload stream into header/body/tail flits for the
// router Local port. Defining NI_STATS_EN adds pkt_cnt / flit_cnt transfer counters.
module ni_packetizer #(
    parameter int DATA_WIDTH  = 32,
    parameter int AXIS        = 4,
    parameter int MAX_PAYLOAD = 4094
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AXIS-1:0] cur_addr,
    ni_packetizer_if.slave  bus,
    output logic            busy,
    output logic            len_err
`ifdef NI_STATS_EN
    ,
    output logic [15:0]     pkt_cnt,
    output logic [15:0]     flit_cnt
`endif
);

    localparam int ID_W  = 3;
    localparam int LEN_W = 12;
    localparam int PAD_W = DATA_WIDTH - ID_W - LEN_W - 2 * AXIS;

    localparam logic [ID_W-1:0]  ID_HDR  = 3'b001;
    localparam logic [ID_W-1:0]  ID_BODY = 3'b010;
    localparam logic [ID_W-1:0]  ID_TAIL = 3'b100;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PAYLOAD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  len_err_q, len_err_d;

    logic                  slot_free;
    logic                  cmd_ready;
    logic                  pl_ready;
    logic                  busy_w;
    logic                  cmd_fire;
    logic                  pl_fire;
    logic                  cmd_legal;
    logic [LEN_W-1:0]      hdr_len;
    logic [DATA_WIDTH-1:0] header_flit;
    logic [ID_W-1:0]       pl_id;

    // The output register may take a new flit when it is empty or its flit leaves this cycle.
    assign slot_free   = !valid_q || bus.ready_in;
    assign cmd_fire    = bus.cmd_valid && cmd_ready;
    assign pl_fire     = bus.pl_valid && pl_ready;
    assign cmd_legal   = (bus.cmd_len != '0) && (bus.cmd_len <= MAX_LEN);
    assign hdr_len     = bus.cmd_len + LEN_W'(1);
    assign header_flit = {ID_HDR, hdr_len, bus.cmd_dst, cur_addr, {PAD_W{1'b0}}};
    assign pl_id       = (rem_q == LEN_W'(1)) ? ID_TAIL : ID_BODY;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire && cmd_legal) begin
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (pl_fire && (rem_q == LEN_W'(1))) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        pl_ready  = 1'b0;
        busy_w    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = slot_free;
            end
            S_PAYLOAD: begin
                pl_ready = slot_free;
                busy_w   = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // Illegal commands are swallowed here: only the error pulse is raised, no flit is loaded.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        rem_d     = rem_q;
        len_err_d = 1'b0;
        if (slot_free) begin
            valid_d = 1'b0;
        end
        if (cmd_fire) begin
            if (cmd_legal) begin
                data_d  = header_flit;
                valid_d = 1'b1;
                rem_d   = bus.cmd_len;
            end else begin
                len_err_d = 1'b1;
            end
        end
        if (pl_fire) begin
            data_d  = {pl_id, bus.pl_data};
            valid_d = 1'b1;
            rem_d   = rem_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            rem_q     <= rem_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            len_err_q <= len_err_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.pl_ready  = pl_ready;
    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign busy          = busy_w;
    assign len_err       = len_err_q;

`ifdef NI_STATS_EN
    localparam int N_CNT = 2;

    logic             flit_xfer;
    logic [N_CNT-1:0] cnt_inc;
    logic [15:0]      cnt_out [N_CNT];

    assign flit_xfer  = valid_q && bus.ready_in;
    assign cnt_inc[0] = flit_xfer && (data_q[DATA_WIDTH-1 -: ID_W] == ID_TAIL);
    assign cnt_inc[1] = flit_xfer;

    // Counter 0 counts completed packets (tail transfers), counter 1 counts every flit; both wrap.
    for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
        logic [15:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (cnt_inc[gi]) begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_out[gi] = cnt_q;
    end

    assign pkt_cnt  = cnt_out[0];
    assign flit_cnt = cnt_out[1];
`endif

endmodule

// File: tb/tb_ni_packetizer.sv
// Self-checking bench for ni_packetizer: directed cases followed by randomized packets with backpressure,
// every flit checked against a queue of expected flits built from the flit-format rules.
module tb_ni_packetizer;
    localparam int DW   = 32;
    localparam int AX   = 4;
    localparam int MAXP = 4094;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AX-1:0] cur_addr = 4'h5;
    logic          busy;
    logic          len_err;
`ifdef NI_STATS_EN
    logic [15:0]   pkt_cnt;
    logic [15:0]   flit_cnt;
`endif

    ni_packetizer_if #(.DATA_WIDTH(DW), .AXIS(AX)) bus ();

    ni_packetizer #(.DATA_WIDTH(DW), .AXIS(AX), .MAX_PAYLOAD(MAXP)) dut (
        .clk(clk),
        .rst(rst),
        .cur_addr(cur_addr),
        .bus(bus),
        .busy(busy),
        .len_err(len_err)
`ifdef NI_STATS_EN
        ,
        .pkt_cnt(pkt_cnt),
        .flit_cnt(flit_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          tail_cyc    = -100;
    int          hdr_cyc     = -100;
    int          exp_pkts    = 0;
    int          exp_flits   = 0;
    bit          bp_random   = 1'b0;
    logic [31:0] exp_q [$];
    logic [28:0] pl_q [$];
    logic [31:0] hdr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_header(input logic [3:0] dst, input logic [3:0] src, input int len);
        return (32'd1 << 29) | (32'(len + 1) << 17) | (32'(dst) << 13) | (32'(src) << 9);
    endfunction

    // Flit monitor: every transfer must match the next expected flit.
    initial forever begin
        @(negedge clk);
        if (!rst && bus.valid_out && bus.ready_in) begin
            check("flit_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("flit", bus.data_out, exp_q.pop_front());
            if (bus.data_out[31:29] == 3'b100) tail_cyc = cyc;
            if (bus.data_out[31:29] == 3'b001) hdr_cyc = cyc;
        end
    end

    // Random backpressure from the router side.
    initial forever begin
        @(posedge clk);
        #1;
        if (bp_random) bus.ready_in = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Tasks start and end one time unit after a rising edge.
    task automatic do_cmd(input logic [3:0] dst, input int len, input bit rnd);
        bit          ok = 1'b0;
        logic [28:0] w;
        bus.cmd_valid = 1'b1;
        bus.cmd_dst   = dst;
        bus.cmd_len   = 12'(len);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("cmd_accept", 32'(ok), 32'd1);
        @(posedge clk);
        if (len >= 1 && len <= MAXP) begin
            exp_q.push_back(model_header(dst, cur_addr, len));
            for (int k = 0; k < len; k++) begin
                w = rnd ? 29'($urandom) : 29'(k + 1);
                pl_q.push_back(w);
                exp_q.push_back(((k == len - 1) ? (32'd4 << 29) : (32'd2 << 29)) | 32'(w));
            end
            exp_pkts++;
            exp_flits += len + 1;
            #1;
            bus.cmd_valid = 1'b0;
        end else begin
            #1;
            bus.cmd_valid = 1'b0;
            @(negedge clk);
            check("len_err_pulse", 32'(len_err), 32'd1);
            check("illegal_no_flit", 32'(bus.valid_out), 32'd0);
            check("illegal_idle", 32'(busy), 32'd0);
            @(negedge clk);
            check("len_err_one_cycle", 32'(len_err), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_payload(input bit gaps, input int nmax);
        int sent = 0;
        bit ok;
        while (pl_q.size() != 0 && sent < nmax) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            bus.pl_valid = 1'b1;
            bus.pl_data  = pl_q.pop_front();
            ok = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (bus.pl_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("pl_accept", 32'(ok), 32'd1);
            check("cmd_ready_in_payload", 32'(bus.cmd_ready), 32'd0);
            check("busy_in_payload", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            bus.pl_valid = 1'b0;
            sent++;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          len;
        int          r;
        logic [3:0]  dst;
        bus.cmd_valid = 1'b0;
        bus.cmd_dst   = '0;
        bus.cmd_len   = '0;
        bus.pl_valid  = 1'b0;
        bus.pl_data   = '0;
        bus.ready_in  = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid_out", 32'(bus.valid_out), 32'd0);
        check("rst_data_out", bus.data_out, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_len_err", 32'(len_err), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_pl_ready", 32'(bus.pl_ready), 32'd0);
`ifdef NI_STATS_EN
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        check("rst_flit_cnt", 32'(flit_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Three-flit payload with fixed words 1, 2, 3.
        do_cmd(4'hA, 3, 1'b0);
        send_payload(1'b0, 4096);
        @(negedge clk);
        check("busy_after_tail", 32'(busy), 32'd0);
        check("tail_word", bus.data_out, 32'h8000_0003);
        @(posedge clk);
        #1;

        // Single payload flit: header length 2, then tail only.
        do_cmd(4'h3, 1, 1'b1);
        @(negedge clk);
        check("len1_header", bus.data_out, model_header(4'h3, cur_addr, 1));
        @(posedge clk);
        #1;
        send_payload(1'b0, 4096);
        drain("drain_len1");

        // Header held under 5 cycles of backpressure.
        bus.ready_in = 1'b0;
        do_cmd(4'h7, 2, 1'b1);
        hdr = model_header(4'h7, cur_addr, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_hold", 32'(bus.valid_out), 32'd1);
            check("bp_data_hold", bus.data_out, hdr);
            check("bp_pl_ready_low", 32'(bus.pl_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.ready_in = 1'b1;
        send_payload(1'b0, 4096);
        drain("drain_bp");

        // Illegal lengths, then a legal command (destination equal to own address).
        do_cmd(4'h2, 0, 1'b0);
        do_cmd(4'h2, 4095, 1'b0);
        do_cmd(4'h5, 2, 1'b1);
        send_payload(1'b0, 4096);
        drain("drain_after_illegal");

        // Back-to-back packets: second header directly after first tail.
        do_cmd(4'hC, 2, 1'b1);
        send_payload(1'b0, 4096);
        do_cmd(4'hD, 2, 1'b1);
        @(posedge clk);
        #1;
        check("b2b_no_bubble", 32'(hdr_cyc - tail_cyc), 32'd1);
        send_payload(1'b0, 4096);
        drain("drain_b2b");

        // Reset while the second of four payload words is pending.
        do_cmd(4'h6, 4, 1'b1);
        send_payload(1'b0, 1);
        bus.pl_valid = 1'b1;
        bus.pl_data  = pl_q[0];
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.pl_valid = 1'b0;
        exp_q.delete();
        pl_q.delete();
        exp_pkts  = 0;
        exp_flits = 0;
        @(negedge clk);
        check("midrst_valid_out", 32'(bus.valid_out), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("midrst_pl_ready", 32'(bus.pl_ready), 32'd0);
        check("midrst_data_out", bus.data_out, 32'd0);
`ifdef NI_STATS_EN
        check("midrst_pkt_cnt", 32'(pkt_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;

        do_cmd(4'h1, 2, 1'b1);
        send_payload(1'b0, 4096);
        drain("drain_post_rst");
`ifdef NI_STATS_EN
        check("one_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check("one_pkt_flit_cnt", 32'(flit_cnt), 32'd3);
`endif

        // Largest legal payload: header length field saturates at 4095.
        do_cmd(4'hF, MAXP, 1'b1);
        @(negedge clk);
        check("max_len_field", 32'(bus.data_out[28:17]), 32'd4095);
        @(posedge clk);
        #1;
        send_payload(1'b0, 4096);
        drain("drain_max");

        // Randomized packets, payload gaps and router backpressure.
        bp_random = 1'b1;
        for (int p = 0; p < 30; p++) begin
            r   = $urandom_range(0, 9);
            len = (r == 0) ? 0 : (r == 1) ? 4095 : $urandom_range(1, 8);
            dst = 4'($urandom);
            do_cmd(dst, len, 1'b1);
            send_payload(1'b1, 4096);
        end
        drain("drain_random");
        bp_random = 1'b0;
        @(posedge clk);
        #1;
        bus.ready_in = 1'b1;
`ifdef NI_STATS_EN
        check("final_pkt_cnt", 32'(pkt_cnt), 32'(16'(exp_pkts)));
        check("final_flit_cnt", 32'(flit_cnt), 32'(16'(exp_flits)));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
